cam_capture_ctrl: RTL and testbench
===================================

# cam_capture_ctrl

Frame-capture controller sitting between the OV7670 parallel pixel port and the write port of the dual-port frame buffer. It pairs RGB565 bytes into RGB332 pixels and generates the buffer write address, data and write strobe for a CAM_SCREEN_X×CAM_SCREEN_Y window. It also sequences single-shot or continuous frame acquisition and reports busy, frame completion and overflow. It runs in the camera pixel-clock domain, so the buffer write clock is the same clock.

## Interface
- AW, 15: buffer address width.
- DW, 8: pixel width (RGB332).
- CAM_SCREEN_X, 160: pixels per line stored.
- CAM_SCREEN_Y, 120: lines per frame stored.

Ports:
- clk  in  1  camera PCLK; camera outputs change on falling edge and are sampled on rising edge. One clock.
- rst  in  1  synchronous, active-high reset.
- cam_vsync  in  1  high = vertical blanking.
- cam_href  in  1  high = valid bytes on cam_px_data.
- cam_px_data  in  8  camera byte bus.
- capture_start  in  1  one-cycle request for a single frame.
- capture_cont  in  1  level; while high, frames are captured back to back.
- mem_px_addr  out  AW  buffer write address.
- mem_px_data  out  DW  RGB332 pixel.
- mem_px_wr  out  1  buffer write enable.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- overflow  out  1  sticky; the current frame delivered more than X×Y pixels.

## Operation
- States: IDLE, ARM, WAIT_FRAME, BYTE_HI, BYTE_LO.
- IDLE: (capture_start | capture_cont) -> ARM.
- ARM: waits for cam_vsync=1 so capture never starts mid-frame. cam_vsync=1 -> WAIT_FRAME.
- WAIT_FRAME: cam_vsync=0 -> BYTE_HI. On this transition: pixel counter := 0, overflow := 0.
- BYTE_HI: cam_href=1 -> latch hi := {b[7:5], b[2:0]} (R[4:2], G[5:3]), go to BYTE_LO.
- BYTE_LO: cam_href=1 -> emit pixel {hi, b[4:3]} (B[4:3]) at the current counter, then increment the counter and go to BYTE_HI.
- BYTE_LO with cam_href=0 (odd byte count in a line): the pending byte is discarded and the state returns to BYTE_HI.
- End of frame: cam_vsync=1 while in BYTE_HI or BYTE_LO. frame_done pulses, then:
  - capture_cont=1 -> WAIT_FRAME.
  - otherwise -> IDLE.
- capture_start while busy is ignored.
- Dropping capture_cont mid-frame finishes the current frame before returning to IDLE.
- Address arithmetic:
  - Counter is AW bits; mem_px_addr = counter.
  - Pixels with counter ≥ X×Y are not written (mem_px_wr=0) and set overflow.
  - The counter saturates at X×Y and never wraps.
  - Address X×Y is never written by this block; it is reserved for the display border colour.

## Timing
- Reset values: mem_px_addr=0, mem_px_data=0, mem_px_wr=0, busy=0, frame_done=0, overflow=0, state IDLE.
- Reset mid-frame abandons the frame. No frame_done is issued for it.
- All outputs are registered.
- Second byte sampled at rising edge k -> mem_px_addr/data/wr valid from edge k through edge k+1. The buffer writes at edge k+1.
- mem_px_wr is high for exactly one cycle per pixel, so at most one write every 2 cycles.
- frame_done is high for the one cycle after the edge at which end-of-frame vsync is sampled. busy drops in the same cycle when returning to IDLE.
- busy rises the cycle after capture_start is sampled.
- No input synchronisers: all inputs belong to the clk domain.

## Structure
- Shared package cam_pkg holds:
  - the CAM_SCREEN_X/Y defaults;
  - the capture state enum;
  - the RGB565-to-RGB332 byte-packing function, shared with any future pattern generator.
- No sub-module: the FSM, pixel counter and packing form one flat block of roughly 150–250 lines.

## Test plan
- Single shot, clean frame: vsync high, then low, then 120 lines × 320 bytes with href, then vsync high -> exactly 19200 writes at addresses 0..19199, frame_done pulses once, busy returns to 0, overflow=0.
- Colour packing: byte pair 0xF8, 0x1F -> mem_px_data=0xE3; pair 0x07, 0xE0 -> 0x1C.
- Mid-frame start: capture_start asserted while vsync=0 in mid-frame -> no writes until the next vsync high→low; the first write lands at address 0.
- Overflow: 121 lines of 160 pixels -> 19200 writes only; overflow=1 after pixel 19200; counter holds at 19200; overflow clears at the next frame start.
- Odd href: a line with 321 bytes -> 160 pixels written, the lone byte dropped, the next line still aligned (first pixel of that line at address 160).
- Continuous plus reset: capture_cont=1 over 3 frames -> 3 frame_done pulses with addresses restarting at 0 each frame. rst asserted mid-frame 2 -> all outputs 0 on the next cycle, state IDLE.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: default window size,
// capture FSM states and the RGB565 -> RGB332 byte packing.
package cam_pkg;

  localparam int CAM_SCREEN_X_DEF = 160;
  localparam int CAM_SCREEN_Y_DEF = 120;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_FRAME,
    BYTE_HI,
    BYTE_LO
  } cap_state_t;

  // First RGB565 byte carries R[4:0],G[5:3]; keep R[4:2] and G[5:3].
  function automatic logic [5:0] rgb565_hi_bits(input logic [7:0] hi_byte);
    return {hi_byte[7:5], hi_byte[2:0]};
  endfunction

  // Second byte carries G[2:0],B[4:0]; keep B[4:3].
  function automatic logic [7:0] rgb332_pack(input logic [5:0] hi_bits,
                                              input logic [7:0] lo_byte);
    return {hi_bits, lo_byte[4:3]};
  endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera pixel port plus frame-buffer write port, both in the PCLK domain.
interface cam_capture_ctrl_if #(
  parameter int AW = 15,
  parameter int DW = 8
) ();

  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          mem_px_wr;

  modport master (
    input  cam_vsync, cam_href, cam_px_data,
    output mem_px_addr, mem_px_data, mem_px_wr
  );

  modport slave (
    output cam_vsync, cam_href, cam_px_data,
    input  mem_px_addr, mem_px_data, mem_px_wr
  );

endinterface

// File: rtl/cam_capture_ctrl.sv
// Frame-capture controller: pairs camera bytes into RGB332 pixels and writes
// them into the frame buffer, sequencing single-shot or continuous frames.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int AW           = 15,
  parameter int DW           = 8,
  parameter int CAM_SCREEN_X = CAM_SCREEN_X_DEF,
  parameter int CAM_SCREEN_Y = CAM_SCREEN_Y_DEF
) (
  input  logic                clk,
  input  logic                rst,
  cam_capture_ctrl_if.master  bus,
  input  logic                capture_start,
  input  logic                capture_cont,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow
);

  // Address X*Y is reserved for the display border, so it is the saturation point.
  localparam logic [AW-1:0] PIX_LIMIT = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

  cap_state_t    state, state_next;
  logic [AW-1:0] pix_cnt;
  logic [5:0]    hi_bits;
  logic          start_frame, end_frame, latch_hi, emit;

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    latch_hi    = 1'b0;
    emit        = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture_start || capture_cont) state_next = ARM;
      end
      ARM: begin
        if (bus.cam_vsync) state_next = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!bus.cam_vsync) begin
          start_frame = 1'b1;
          state_next  = BYTE_HI;
        end
      end
      BYTE_HI: begin
        if (bus.cam_vsync) begin
          end_frame  = 1'b1;
          state_next = capture_cont ? WAIT_FRAME : IDLE;
        end else if (bus.cam_href) begin
          latch_hi   = 1'b1;
          state_next = BYTE_LO;
        end
      end
      BYTE_LO: begin
        // A missing second byte drops the lone first byte to keep lines aligned.
        if (bus.cam_vsync) begin
          end_frame  = 1'b1;
          state_next = capture_cont ? WAIT_FRAME : IDLE;
        end else begin
          emit       = bus.cam_href;
          state_next = BYTE_HI;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      hi_bits         <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      overflow        <= 1'b0;
      bus.mem_px_addr <= '0;
      bus.mem_px_data <= '0;
      bus.mem_px_wr   <= 1'b0;
    end else begin
      state         <= state_next;
      busy          <= (state_next != IDLE);
      frame_done    <= end_frame;
      bus.mem_px_wr <= 1'b0;
      if (start_frame) begin
        pix_cnt  <= '0;
        overflow <= 1'b0;
      end
      if (latch_hi) hi_bits <= rgb565_hi_bits(bus.cam_px_data);
      if (emit) begin
        bus.mem_px_addr <= pix_cnt;
        bus.mem_px_data <= DW'(rgb332_pack(hi_bits, bus.cam_px_data));
        if (pix_cnt < PIX_LIMIT) begin
          bus.mem_px_wr <= 1'b1;
          pix_cnt       <= pix_cnt + AW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: drives camera timing on the falling
// edge and checks buffer writes, frame sequencing and overflow behaviour.
module tb_cam_capture_ctrl;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int X  = 160;
  localparam int Y  = 120;
  localparam int XY = X * Y;

  logic clk = 1'b0;
  logic rst;
  logic capture_start;
  logic capture_cont;
  logic busy;
  logic frame_done;
  logic overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_capture_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  cam_capture_ctrl #(
    .AW(AW), .DW(DW), .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .capture_start(capture_start),
    .capture_cont(capture_cont),
    .busy(busy),
    .frame_done(frame_done),
    .overflow(overflow)
  );

  // Write monitor: every write must land on the next expected address.
  int          wr_total   = 0;
  int          done_total = 0;
  int          addr_err   = 0;
  int          oob        = 0;
  int          b2b        = 0;
  int          exp_addr   = 0;
  int          probe_addr = -1;
  logic [7:0]  probe_data = 8'h00;
  logic [AW-1:0] last_addr = '0;
  logic [7:0]  last_data  = 8'h00;
  logic        prev_wr    = 1'b0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      prev_wr = 1'b0;
    end else begin
      if (bus.mem_px_wr === 1'b1) begin
        if (int'(bus.mem_px_addr) != exp_addr) addr_err++;
        if (int'(bus.mem_px_addr) >= XY) oob++;
        if (prev_wr) b2b++;
        if (int'(bus.mem_px_addr) == probe_addr) probe_data = bus.mem_px_data;
        last_addr = bus.mem_px_addr;
        last_data = bus.mem_px_data;
        wr_total++;
        exp_addr++;
      end
      prev_wr = (bus.mem_px_wr === 1'b1);
      if (frame_done === 1'b1) done_total++;
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
    bus.cam_vsync   = vs;
    bus.cam_href    = hr;
    bus.cam_px_data = d;
    tick(1);
  endtask

  function automatic logic [7:0] lineByte(input int mode, input int i, input int n);
    case (mode)
      1:       return (i == n - 1) ? 8'hFF : 8'h00;
      2:       return (i % 2 == 0) ? 8'h07 : 8'hE0;
      default: return i[7:0];
    endcase
  endfunction

  task automatic sendLine(input int nbytes, input int mode);
    for (int i = 0; i < nbytes; i++) applyStimulus(1'b0, 1'b1, lineByte(mode, i, nbytes));
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic startFrame();
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulseStart();
    bus.cam_vsync = 1'b1;
    capture_start = 1'b1;
    tick(1);
    capture_start = 1'b0;
  endtask

  task automatic endFrame(input string tag, input logic expect_busy);
    logic seen;
    logic busy_at;
    seen    = 1'b0;
    busy_at = 1'bx;
    bus.cam_vsync = 1'b1;
    bus.cam_href  = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick(1);
      if (frame_done === 1'b1) begin
        seen    = 1'b1;
        busy_at = busy;
      end
    end
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy_at), 32'(expect_busy));
    tick(2);
  endtask

  int w0, d0;

  initial begin
    rst           = 1'b1;
    capture_start = 1'b0;
    capture_cont  = 1'b0;
    bus.cam_vsync   = 1'b0;
    bus.cam_href    = 1'b0;
    bus.cam_px_data = 8'h00;
    tick(3);
    checkOutput("rst_addr", 32'(bus.mem_px_addr), 32'd0);
    checkOutput("rst_data", 32'(bus.mem_px_data), 32'd0);
    checkOutput("rst_wr", 32'(bus.mem_px_wr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(2);

    // Colour packing on two hand-computed byte pairs
    w0 = wr_total;
    pulseStart();
    checkOutput("busy_rise", 32'(busy), 32'd1);
    exp_addr = 0;
    startFrame();
    applyStimulus(1'b0, 1'b1, 8'hF8);
    applyStimulus(1'b0, 1'b1, 8'h1F);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("pack_f81f", 32'(last_data), 32'hE3);
    checkOutput("pack_addr0", 32'(last_addr), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h07);
    applyStimulus(1'b0, 1'b1, 8'hE0);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("pack_07e0", 32'(last_data), 32'h1C);
    checkOutput("pack_addr1", 32'(last_addr), 32'd1);
    endFrame("pack", 1'b0);
    checkOutput("pack_writes", 32'(wr_total - w0), 32'd2);

    // Clean full-size single-shot frame
    w0 = wr_total;
    d0 = done_total;
    pulseStart();
    exp_addr = 0;
    startFrame();
    for (int l = 0; l < Y; l++) sendLine(2 * X, 0);
    endFrame("clean", 1'b0);
    checkOutput("clean_writes", 32'(wr_total - w0), 32'(XY));
    checkOutput("clean_last", 32'(last_addr), 32'(XY - 1));
    checkOutput("clean_dones", 32'(done_total - d0), 32'd1);
    checkOutput("clean_ovf", 32'(overflow), 32'd0);
    checkOutput("clean_seq", 32'(addr_err), 32'd0);
    checkOutput("clean_b2b", 32'(b2b), 32'd0);

    // Back in IDLE: another camera frame must not be captured
    w0 = wr_total;
    startFrame();
    sendLine(16, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick(2);
    checkOutput("idle_nowr", 32'(wr_total - w0), 32'd0);

    // Start request in mid-frame waits for the next frame boundary
    w0 = wr_total;
    bus.cam_vsync = 1'b0;
    capture_start = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h55);
    capture_start = 1'b0;
    sendLine(2 * X, 0);
    sendLine(2 * X, 0);
    checkOutput("mid_nowr", 32'(wr_total - w0), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    exp_addr = 0;
    startFrame();
    sendLine(2 * X, 0);
    capture_start = 1'b1;
    tick(1);
    capture_start = 1'b0;
    sendLine(2 * X, 0);
    endFrame("mid", 1'b0);
    checkOutput("mid_writes", 32'(wr_total - w0), 32'(2 * X));
    checkOutput("mid_last", 32'(last_addr), 32'(2 * X - 1));
    checkOutput("mid_seq", 32'(addr_err), 32'd0);
    tick(4);
    checkOutput("mid_idle", 32'(busy), 32'd0);

    // Odd byte count: the lone byte is dropped and the next line stays aligned
    w0 = wr_total;
    pulseStart();
    exp_addr   = 0;
    probe_addr = X;
    probe_data = 8'h00;
    startFrame();
    sendLine(2 * X + 1, 1);
    sendLine(2 * X, 2);
    endFrame("odd", 1'b0);
    checkOutput("odd_writes", 32'(wr_total - w0), 32'(2 * X));
    checkOutput("odd_seq", 32'(addr_err), 32'd0);
    checkOutput("odd_align", 32'(probe_data), 32'h1C);
    probe_addr = -1;

    // Overflow: 121 lines, writes stop at X*Y and the counter saturates
    w0 = wr_total;
    pulseStart();
    exp_addr = 0;
    startFrame();
    for (int l = 0; l < Y; l++) sendLine(2 * X, 0);
    checkOutput("ovf_before", 32'(overflow), 32'd0);
    sendLine(2 * X, 0);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_addr", 32'(bus.mem_px_addr), 32'(XY));
    checkOutput("ovf_writes", 32'(wr_total - w0), 32'(XY));
    checkOutput("ovf_oob", 32'(oob), 32'd0);
    endFrame("ovf", 1'b0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Continuous capture over three short frames
    w0 = wr_total;
    d0 = done_total;
    capture_cont = 1'b1;
    for (int f = 0; f < 3; f++) begin
      exp_addr = 0;
      startFrame();
      if (f == 0) checkOutput("ovf_clear", 32'(overflow), 32'd0);
      sendLine(8, 0);
      endFrame("cont", 1'b1);
    end
    checkOutput("cont_dones", 32'(done_total - d0), 32'd3);
    checkOutput("cont_writes", 32'(wr_total - w0), 32'd12);
    checkOutput("cont_seq", 32'(addr_err), 32'd0);
    checkOutput("cont_last", 32'(last_addr), 32'd3);

    // Dropping capture_cont mid-frame completes that frame, then IDLE
    w0 = wr_total;
    exp_addr = 0;
    startFrame();
    sendLine(8, 0);
    capture_cont = 1'b0;
    sendLine(8, 0);
    endFrame("drop", 1'b0);
    checkOutput("drop_writes", 32'(wr_total - w0), 32'd8);

    // Reset in the middle of the second continuous frame
    capture_cont = 1'b1;
    exp_addr = 0;
    startFrame();
    sendLine(8, 0);
    endFrame("cont2", 1'b1);
    startFrame();
    applyStimulus(1'b0, 1'b1, 8'hF8);
    bus.cam_px_data = 8'h1F;
    rst = 1'b1;
    tick(1);
    checkOutput("mrst_addr", 32'(bus.mem_px_addr), 32'd0);
    checkOutput("mrst_data", 32'(bus.mem_px_data), 32'd0);
    checkOutput("mrst_wr", 32'(bus.mem_px_wr), 32'd0);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_done", 32'(frame_done), 32'd0);
    checkOutput("mrst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    capture_cont = 1'b0;
    w0 = wr_total;
    d0 = done_total;
    applyStimulus(1'b0, 1'b0, 8'h00);
    sendLine(8, 0);
    startFrame();
    sendLine(8, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick(3);
    checkOutput("mrst_nodone", 32'(done_total - d0), 32'd0);
    checkOutput("mrst_nowr", 32'(wr_total - w0), 32'd0);
    checkOutput("mrst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
